// File: rtl/icache_mem_responder_if.sv
// Request/response bundle between the fetch/prefetch controller (master)
// and the memory-side responder (slave).
interface icache_mem_responder_if;

   // Command issued by the fetch path: 0 NONE, 1 LOAD, 2 STORE, 3 NONE
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data;

   // Same-cycle acceptance tag, then the later completion tag and data
   logic [3:0]  mem2proc_response;
   logic [3:0]  mem2proc_tag;
   logic [63:0] mem2proc_data;

   modport master (
      output proc2mem_command,
      output proc2mem_addr,
      output proc2mem_data,
      input  mem2proc_response,
      input  mem2proc_tag,
      input  mem2proc_data
   );

   modport slave (
      input  proc2mem_command,
      input  proc2mem_addr,
      input  proc2mem_data,
      output mem2proc_response,
      output mem2proc_tag,
      output mem2proc_data
   );

endinterface

// File: rtl/icache_mem_responder.sv
// Memory-side responder for instruction fetch. It accepts one LOAD or STORE
// per cycle, hands out a nonzero round-robin tag immediately, and returns the
// tag with 64-bit data a fixed number of cycles later, in acceptance order.
// A small word-addressed store stands in for external memory.
module icache_mem_responder #(
   parameter int MEM_LATENCY     = 4,
   parameter int MAX_OUTSTANDING = 15,
   parameter int IDX_W           = 8
) (
   input logic                  clock,
   input logic                  reset,
   icache_mem_responder_if.slave bus
);

   localparam int         DEPTH   = 1 << IDX_W;
   localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_LOAD  = 2'd1,
      CMD_STORE = 2'd2,
      CMD_RSVD  = 2'd3
   } cmd_e;

   cmd_e             cmd;
   logic             is_load;
   logic             is_store;
   logic             last_valid;
   logic             has_room;
   logic             accept;
   logic [IDX_W-1:0] word_idx;
   logic [63:0]      payload;
   logic             unused_addr_bits;

   logic [3:0]  next_tag_q, next_tag_d;
   logic [4:0]  outstanding_q, outstanding_d;

   logic        stage_valid_q [MEM_LATENCY];
   logic        stage_valid_d [MEM_LATENCY];
   logic [3:0]  stage_tag_q   [MEM_LATENCY];
   logic [3:0]  stage_tag_d   [MEM_LATENCY];
   logic [63:0] stage_data_q  [MEM_LATENCY];
   logic [63:0] stage_data_d  [MEM_LATENCY];

   logic [63:0] mem_q [DEPTH];
   logic [63:0] mem_d [DEPTH];

   assign cmd      = cmd_e'(bus.proc2mem_command);
   assign is_load  = (cmd == CMD_LOAD);
   assign is_store = (cmd == CMD_STORE);

   // Bits outside the word index are deliberately ignored, so addresses alias
   assign word_idx         = bus.proc2mem_addr[IDX_W+2:3];
   assign unused_addr_bits = ^{bus.proc2mem_addr[31:IDX_W+3], bus.proc2mem_addr[2:0]};

   // A transaction completing this cycle frees its slot in time for a new accept
   always_comb begin
      last_valid = stage_valid_q[MEM_LATENCY-1];
      has_room   = (outstanding_q - {4'd0, last_valid}) < MAX_OUT;
      accept     = (is_load || is_store) && has_room && !reset;
   end

   // Loads snapshot the array now; stores echo their own write data
   always_comb begin
      payload = is_store ? bus.proc2mem_data : mem_q[word_idx];
   end

   // Tag handed back in the same cycle; zero means nothing was taken
   always_comb begin
      bus.mem2proc_response = accept ? next_tag_q : 4'd0;
   end

   // Round-robin tag skips 0; FIFO completion keeps it from hitting a live tag
   always_comb begin
      next_tag_d = next_tag_q;
      if (accept) begin
         next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
      end
   end

   // Live transaction count: up on accept, down on completion
   always_comb begin
      outstanding_d = outstanding_q + {4'd0, accept} - {4'd0, last_valid};
   end

   // Shift pipeline: the new entry enters stage 0, everything moves one step
   always_comb begin
      stage_valid_d = stage_valid_q;
      stage_tag_d   = stage_tag_q;
      stage_data_d  = stage_data_q;
      stage_valid_d[0] = accept;
      stage_tag_d[0]   = accept ? next_tag_q : 4'd0;
      stage_data_d[0]  = accept ? payload : 64'd0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         stage_valid_d[i] = stage_valid_q[i-1];
         stage_tag_d[i]   = stage_tag_q[i-1];
         stage_data_d[i]  = stage_data_q[i-1];
      end
   end

   // Backing store update on an accepted STORE
   always_comb begin
      mem_d = mem_q;
      if (accept && is_store) begin
         mem_d[word_idx] = bus.proc2mem_data;
      end
   end

   // Completion outputs come straight from the last pipeline stage
   always_comb begin
      bus.mem2proc_tag  = last_valid ? stage_tag_q[MEM_LATENCY-1]  : 4'd0;
      bus.mem2proc_data = last_valid ? stage_data_q[MEM_LATENCY-1] : 64'd0;
   end

   // Control and pipeline state; reset drops all in-flight work
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         next_tag_q    <= 4'd1;
         outstanding_q <= 5'd0;
         for (int i = 0; i < MEM_LATENCY; i++) begin
            stage_valid_q[i] <= 1'b0;
            stage_tag_q[i]   <= 4'd0;
            stage_data_q[i]  <= 64'd0;
         end
      end else begin
         next_tag_q    <= next_tag_d;
         outstanding_q <= outstanding_d;
         stage_valid_q <= stage_valid_d;
         stage_tag_q   <= stage_tag_d;
         stage_data_q  <= stage_data_d;
      end
   end

   // Memory array; reset clears every word
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 64'd0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: tb/tb_icache_mem_responder.sv
// Testbench for icache_mem_responder: a default-parameter instance plus a
// MAX_OUTSTANDING=2 instance. The driver pushes expected completions into a
// queue per instance; a monitor per instance pops and compares each cycle.
module tb_icache_mem_responder;

   localparam logic [1:0] C_NONE  = 2'd0;
   localparam logic [1:0] C_LOAD  = 2'd1;
   localparam logic [1:0] C_STORE = 2'd2;
   localparam int         LAT     = 4;

   typedef struct {
      logic [3:0]  tag;
      logic [63:0] data;
      int          due;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cycle_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];

   icache_mem_responder_if ifa ();
   icache_mem_responder_if ifb ();

   icache_mem_responder #(.MEM_LATENCY(4), .MAX_OUTSTANDING(15), .IDX_W(8)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (ifa.slave)
   );

   icache_mem_responder #(.MEM_LATENCY(4), .MAX_OUTSTANDING(2), .IDX_W(8)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (ifb.slave)
   );

   // Free-running clock and cycle counter
   always #5 clock = ~clock;

   always @(posedge clock) cycle_cnt++;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle_cnt);
      end
   endtask

   // Monitor for instance A: completion tag/data compared every cycle
   always @(negedge clock) begin
      logic [3:0]  et;
      logic [63:0] ed;
      if (!reset) begin
         et = 4'd0;
         ed = 64'd0;
         if (qa.size() > 0 && qa[0].due == cycle_cnt) begin
            et = qa[0].tag;
            ed = qa[0].data;
            void'(qa.pop_front());
         end
         checkOutput("a_tag", {60'd0, ifa.mem2proc_tag}, {60'd0, et});
         checkOutput("a_data", ifa.mem2proc_data, ed);
      end
   end

   // Monitor for instance B
   always @(negedge clock) begin
      logic [3:0]  et;
      logic [63:0] ed;
      if (!reset) begin
         et = 4'd0;
         ed = 64'd0;
         if (qb.size() > 0 && qb[0].due == cycle_cnt) begin
            et = qb[0].tag;
            ed = qb[0].data;
            void'(qb.pop_front());
         end
         checkOutput("b_tag", {60'd0, ifb.mem2proc_tag}, {60'd0, et});
         checkOutput("b_data", ifb.mem2proc_data, ed);
      end
   end

   // One command on instance A for one cycle, response checked mid-cycle
   task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data,
                                input logic [3:0] exp_resp, input logic [63:0] exp_data);
      exp_t e;
      @(posedge clock);
      #1;
      ifa.proc2mem_command = cmd;
      ifa.proc2mem_addr    = addr;
      ifa.proc2mem_data    = data;
      #3;
      checkOutput("a_response", {60'd0, ifa.mem2proc_response}, {60'd0, exp_resp});
      if (exp_resp != 4'd0) begin
         e.tag  = exp_resp;
         e.data = exp_data;
         e.due  = cycle_cnt + LAT;
         qa.push_back(e);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
         ifa.proc2mem_command = C_NONE;
         ifb.proc2mem_command = C_NONE;
      end
   endtask

   task automatic drain();
      idleCycles(1);
      for (int i = 0; i < 40; i++) begin
         if (qa.size() == 0 && qb.size() == 0) break;
         @(posedge clock);
      end
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: pending a=%0d b=%0d expected 0", qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   // Reset with a LOAD held on A so a suppressed response is meaningful
   task automatic doReset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      ifa.proc2mem_command = C_LOAD;
      ifb.proc2mem_command = C_LOAD;
      qa.delete();
      qb.delete();
      #1;
      checkOutput("rst_a_response", {60'd0, ifa.mem2proc_response}, 64'd0);
      checkOutput("rst_b_response", {60'd0, ifb.mem2proc_response}, 64'd0);
      checkOutput("rst_a_tag", {60'd0, ifa.mem2proc_tag}, 64'd0);
      checkOutput("rst_a_data", ifa.mem2proc_data, 64'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      ifa.proc2mem_command = C_NONE;
      ifb.proc2mem_command = C_NONE;
   endtask

   initial begin
      logic [3:0] b_exp [12];
      exp_t       e;

      ifa.proc2mem_command = C_NONE;
      ifa.proc2mem_addr    = 32'd0;
      ifa.proc2mem_data    = 64'd0;
      ifb.proc2mem_command = C_NONE;
      ifb.proc2mem_addr    = 32'd0;
      ifb.proc2mem_data    = 64'd0;

      // Single LOAD after reset: tag 1, data 0, quiet cycles around it
      $display("[TB] single load after reset");
      doReset();
      applyStimulus(C_LOAD, 32'h0, 64'd0, 4'd1, 64'd0);
      drain();

      // STORE then LOAD of the same word
      $display("[TB] store then load");
      doReset();
      applyStimulus(C_STORE, 32'h10, 64'hDEAD_BEEF_0123_4567, 4'd1, 64'hDEAD_BEEF_0123_4567);
      applyStimulus(C_LOAD,  32'h10, 64'd0,                   4'd2, 64'hDEAD_BEEF_0123_4567);
      drain();

      // Address aliasing above the index bits
      $display("[TB] address aliasing");
      doReset();
      applyStimulus(C_STORE, 32'h0000_0808, 64'h1122_3344_5566_7788, 4'd1, 64'h1122_3344_5566_7788);
      applyStimulus(C_LOAD,  32'h0000_0008, 64'd0,                   4'd2, 64'h1122_3344_5566_7788);
      applyStimulus(C_LOAD,  32'h0000_0010, 64'd0,                   4'd3, 64'd0);
      applyStimulus(C_LOAD,  32'h0000_0009, 64'd0,                   4'd4, 64'h1122_3344_5566_7788);
      drain();

      // 20 back-to-back loads: tags 1..15 then wrap to 1..5
      $display("[TB] back-to-back loads with tag wrap");
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(C_LOAD, 32'(i * 8), 64'd0, 4'((i % 15) + 1), 64'd0);
      end
      drain();

      // In-flight load keeps its pre-store snapshot
      $display("[TB] load snapshot vs later store");
      doReset();
      applyStimulus(C_LOAD,  32'h20, 64'd0, 4'd1, 64'd0);
      applyStimulus(C_STORE, 32'h20, 64'h5, 4'd2, 64'h5);
      applyStimulus(C_LOAD,  32'h20, 64'd0, 4'd3, 64'h5);
      drain();

      // Reset while tag 1 is completing drops it and tag 2 as well
      $display("[TB] reset drops in-flight work");
      doReset();
      applyStimulus(C_STORE, 32'h40, 64'hCAFE_F00D_0000_0001, 4'd1, 64'hCAFE_F00D_0000_0001);
      applyStimulus(C_LOAD,  32'h40, 64'd0,                   4'd2, 64'hCAFE_F00D_0000_0001);
      idleCycles(2);
      @(posedge clock);
      #2;
      checkOutput("pre_reset_tag", {60'd0, ifa.mem2proc_tag}, 64'd1);
      reset = 1'b1;
      ifa.proc2mem_command = C_LOAD;
      qa.delete();
      qb.delete();
      #1;
      checkOutput("async_reset_tag", {60'd0, ifa.mem2proc_tag}, 64'd0);
      checkOutput("async_reset_data", ifa.mem2proc_data, 64'd0);
      checkOutput("async_reset_response", {60'd0, ifa.mem2proc_response}, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      ifa.proc2mem_command = C_NONE;
      applyStimulus(C_LOAD, 32'h40, 64'd0, 4'd1, 64'd0);
      drain();

      // Instance B: two live tags, LOAD held every cycle
      $display("[TB] limited outstanding stalls");
      doReset();
      b_exp = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd3, 4'd4, 4'd0, 4'd0, 4'd5, 4'd6, 4'd0, 4'd0};
      for (int i = 0; i < 12; i++) begin
         @(posedge clock);
         #1;
         ifb.proc2mem_command = C_LOAD;
         ifb.proc2mem_addr    = 32'(i * 8);
         #3;
         checkOutput("b_response", {60'd0, ifb.mem2proc_response}, {60'd0, b_exp[i]});
         if (b_exp[i] != 4'd0) begin
            e.tag  = b_exp[i];
            e.data = 64'd0;
            e.due  = cycle_cnt + LAT;
            qb.push_back(e);
         end
      end
      drain();

      idleCycles(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_mem_responder.md
# icache_mem_responder

Memory-side responder for the instruction-fetch request interface: it accepts one load or store command per cycle from the fetch/prefetch controller and hands back a nonzero 4-bit transaction tag in the same cycle. After a fixed latency it returns the tag and 64-bit data. The tag stream it produces is the one the prefetcher and I-cache controller consume to match returning lines to outstanding addresses. It backs a small internal word-addressed store, so the fetch path can be exercised and synthesized without the external memory model.

## Interface
- MEM_LATENCY, 4: cycles from acceptance to completion; legal range 1..15.
- MAX_OUTSTANDING, 15: maximum live tags; legal range 1..15, and must be ≥ MEM_LATENCY for full throughput.
- IDX_W, 8: word-index width; internal store is 2^IDX_W × 64 bits.
- clock  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- proc2mem_command  in  2  command: 0 NONE, 1 LOAD, 2 STORE, 3 treated as NONE.
- proc2mem_addr  in  32  byte address; word index = addr[IDX_W+2:3]; other bits ignored (aliasing).
- proc2mem_data  in  64  store data.
- mem2proc_response  out  4  combinational; tag assigned to this cycle's command, 0 = not accepted or no command.
- mem2proc_tag  out  4  registered; tag of the transaction completing this cycle, 0 = none.
- mem2proc_data  out  64  registered; data for the completing transaction, 0 when mem2proc_tag = 0.

## Operation
- State:
  - next_tag, cycles 1..15 and skips 0; reset value 1.
  - Shift pipeline of MEM_LATENCY stages. Each stage holds {valid, tag[3:0], data[63:0]}.
  - outstanding, a count of valid stages.
  - Memory array.
- Accept condition: command ∈ {LOAD, STORE} and (outstanding − last_stage_valid) < MAX_OUTSTANDING. A tag completing this cycle counts as already free.
- On accept:
  - mem2proc_response = next_tag; next_tag advances at the edge (15 → 1).
  - Stage 1 loads {1, next_tag, payload}.
- Rejected or NONE: response 0; no state change except pipeline shift.
- LOAD payload = memory[index] sampled at the accepting edge. The value is snapshotted, so later stores do not affect in-flight loads.
- STORE:
  - memory[index] ← proc2mem_data at the accepting edge.
  - Payload = proc2mem_data; the store completion echoes the written data.
- Each edge: stage i+1 ← stage i; stage 1 ← new entry or invalid.
- The last stage drives mem2proc_tag / mem2proc_data: tag and data when valid, else 0.
- Completions are strictly in acceptance order, at most one per cycle. Tags are freed in FIFO order, so round-robin next_tag never collides with a live tag.
- outstanding:
  - +1 on accept, −1 when the last stage is valid.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds MAX_OUTSTANDING.

## Timing
- Request presented in cycle k and accepted:
  - response nonzero in cycle k (combinational from command and state).
  - mem2proc_tag equals that tag in cycle k+MEM_LATENCY, for exactly one cycle.
- Throughput: one accept per cycle when MAX_OUTSTANDING ≥ MEM_LATENCY.
- With MAX_OUTSTANDING < MEM_LATENCY, requests stall (response 0) until the oldest tag is in its completion cycle; the requester must retry.
- Reset asserted, asynchronous:
  - Immediately: mem2proc_tag = 0, mem2proc_data = 0, mem2proc_response = 0, all stages invalid, outstanding = 0, next_tag = 1, memory zeroed.
  - In-flight transactions are dropped and never complete.
- After reset deasserts, the first accepted command receives tag 1.
- Wrap: tag 15 is followed by tag 1. Tag 0 is never issued.
- Address bits above IDX_W+2 alias: 0x0000_0008 and 0x0000_0808 (IDX_W = 8) hit the same word.

## Test plan
- Reset, then LOAD 0x0 in cycle 0 (default params) -> response 1 in cycle 0; mem2proc_tag = 1, data = 0 in cycle 4; tag 0 in cycles 1–3 and 5.
- STORE 0x10 data 0xDEAD_BEEF_0123_4567 (tag 1), then LOAD 0x10 next cycle (tag 2) -> cycle 4: tag 1 with the store data; cycle 5: tag 2 with 0xDEAD_BEEF_0123_4567.
- 20 back-to-back LOADs -> responses 1..15, 1..5, no zeros; completions in the same order, each 4 cycles after its issue.
- MAX_OUTSTANDING = 2, MEM_LATENCY = 4, LOAD held every cycle from cycle 0 -> responses 1,2,0,0,3,4,0,0,5…; a new tag is accepted in each cycle where an old tag completes.
- LOAD in cycle 0 (tag 1), reset pulse in cycle 2 -> no completion ever appears for tag 1; the next LOAD after reset gets tag 1; all outputs are 0 during reset.
- LOAD 0x20 (tag 1), then STORE 0x20 data 0x5 next cycle -> tag 1 completes with the pre-store value 0, not 0x5.
